sw_rr: RTL and testbench

- Parametrised N-port input-buffered packet switch; next generation of the fixed 4x4 switch.
- Each input has a FIFO of configurable depth. Each output has a round-robin arbiter and a registered output stage with a valid/ready handshake.
- Adds over the 4x4 switch: backpressure flag per input, source-port tag on outputs, invalid-destination filtering, saturating per-input drop counters.
- Sits between link receivers and link transmitters in the network fabric.

---
 rtl/sw_rr.sv | 206 ++++++++++++++++++++
 tb/tb_sw_rr.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_rr.sv
// ---------------------------------------------------------------------------
// sw_rr -- N-port input-buffered packet switch with per-output round-robin
//
// Each input owns a circular FIFO. The head packet of every non-empty FIFO
// requests the output named by its dest field. Each output runs its own
// round-robin arbiter and drives a registered valid/ready output stage.
// Packets with an out-of-range dest, or presented while their FIFO is full,
// are dropped and counted in a saturating per-input counter.
//
// Packet format: {dest[DEST_W-1:0], payload[DATA_W-1:0]}, dest in the MSBs.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   [NPORT]          per-input packet strobe
//   in_pkt     [NPORT*PKT_W]    input packets, port i at [i*PKT_W +: PKT_W]
//   in_full    [NPORT]          input FIFO holds DEPTH packets
//   out_valid  [NPORT]          output stage holds a packet
//   out_ready  [NPORT]          downstream accepts output j this cycle
//   out_pkt    [NPORT*PKT_W]    output packets, unmodified {dest, payload}
//   out_src    [NPORT*DEST_W]   input index that sourced out_pkt j
//   drop_cnt   [NPORT*CNT_W]    per-input saturating drop counters
// ---------------------------------------------------------------------------
module sw_rr #(
  parameter  int NPORT  = 4,
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  parameter  int CNT_W  = 8,
  localparam int DEST_W = (NPORT > 1) ? $clog2(NPORT) : 1,
  localparam int PKT_W  = DEST_W + DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORT-1:0]          in_valid,
  input  logic [NPORT*PKT_W-1:0]    in_pkt,
  output logic [NPORT-1:0]          in_full,
  output logic [NPORT-1:0]          out_valid,
  input  logic [NPORT-1:0]          out_ready,
  output logic [NPORT*PKT_W-1:0]    out_pkt,
  output logic [NPORT*DEST_W-1:0]   out_src,
  output logic [NPORT*CNT_W-1:0]    drop_cnt
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Input FIFO state
  logic [PKT_W-1:0]  mem     [NPORT][DEPTH];
  logic [PTR_W-1:0]  wr_ptr  [NPORT];
  logic [PTR_W-1:0]  rd_ptr  [NPORT];
  logic [PTR_W:0]    count   [NPORT];
  logic [CNT_W-1:0]  drops   [NPORT];

  // Per-input decode
  logic [PKT_W-1:0]  pkt_in    [NPORT];
  logic [PKT_W-1:0]  head      [NPORT];
  logic [DEST_W-1:0] head_dest [NPORT];
  logic [NPORT-1:0]  full_w;
  logic [NPORT-1:0]  push;
  logic [NPORT-1:0]  drop;
  logic [NPORT-1:0]  pop;

  // Arbitration: req[j][i] = input i wants output j
  logic [NPORT-1:0]  req     [NPORT];
  logic [NPORT-1:0]  free;
  logic [NPORT-1:0]  gnt_valid;
  logic [DEST_W-1:0] gnt_idx [NPORT];
  logic [DEST_W-1:0] rr_ptr  [NPORT];

  // Output stage registers
  logic [NPORT-1:0]  ovalid_q;
  logic [PKT_W-1:0]  opkt_q  [NPORT];
  logic [DEST_W-1:0] osrc_q  [NPORT];

  // -------------------------------------------------------------------------
  // Input side: unpack, full flag, accept/drop decision
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      pkt_in[i]    = in_pkt[i*PKT_W +: PKT_W];
      head[i]      = mem[i][rd_ptr[i]];
      head_dest[i] = head[i][PKT_W-1 -: DEST_W];
      // Full is taken from the registered count, so a pop in the same cycle
      // never rescues a packet presented to a full FIFO.
      full_w[i]    = (count[i] == FULL_CNT);
      push[i]      = in_valid[i] && !full_w[i] &&
                     (int'(pkt_in[i][PKT_W-1 -: DEST_W]) < NPORT);
      drop[i]      = in_valid[i] && !push[i];
    end
  end

  assign in_full = full_w;

  // -------------------------------------------------------------------------
  // Request matrix, per-output round-robin arbitration, pop generation
  // -------------------------------------------------------------------------
  always_comb begin
    int                idx;
    logic [DEST_W-1:0] cand;
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    idx       = 0;
    cand      = '0;
    gnt_valid = '0;
    pop       = '0;
    free      = '0;
    for (int j = 0; j < NPORT; j++) begin
      gnt_idx[j] = '0;
      req[j]     = '0;
      for (int i = 0; i < NPORT; i++)
        req[j][i] = (count[i] != '0) && (int'(head_dest[i]) == j);
    end

    for (int j = 0; j < NPORT; j++) begin
      free[j] = !ovalid_q[j] || out_ready[j];
      if (free[j]) begin
        // Scan from rr_ptr upward, wrapping at NPORT; first requester wins.
        for (int k = 0; k < NPORT; k++) begin
          idx = int'(rr_ptr[j]) + k;
          if (idx >= NPORT) idx = idx - NPORT;
          cand = DEST_W'(idx);
          if (!gnt_valid[j] && req[j][cand]) begin
            gnt_valid[j] = 1'b1;
            gnt_idx[j]   = cand;
          end
        end
      end
    end

    // An input has a single head, so at most one output can grant it.
    for (int i = 0; i < NPORT; i++)
      for (int j = 0; j < NPORT; j++)
        if (gnt_valid[j] && int'(gnt_idx[j]) == i) pop[i] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // FIFO storage
  // -------------------------------------------------------------------------
  // NOTE: the packet array is not reset; stale contents are unreachable once
  // the pointers and counts are cleared, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORT; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= pkt_in[i];
  end

  // -------------------------------------------------------------------------
  // FIFO control, drop counters, output stages, round-robin pointers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovalid_q <= '0;
      for (int i = 0; i < NPORT; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        drops[i]  <= '0;
        opkt_q[i] <= '0;
        osrc_q[i] <= '0;
        rr_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        // DEPTH is a power of two, so pointer increments wrap naturally.
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
        if (drop[i] && (drops[i] != '1)) drops[i] <= drops[i] + 1'b1;
      end

      for (int j = 0; j < NPORT; j++) begin
        if (gnt_valid[j]) begin
          ovalid_q[j] <= 1'b1;
          opkt_q[j]   <= head[gnt_idx[j]];
          osrc_q[j]   <= gnt_idx[j];
          rr_ptr[j]   <= (int'(gnt_idx[j]) == NPORT-1) ? '0 : gnt_idx[j] + 1'b1;
        end else if (free[j]) begin
          // Payload and source hold their last values; only valid drops.
          ovalid_q[j] <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Flatten outputs
  // -------------------------------------------------------------------------
  assign out_valid = ovalid_q;

  always_comb begin
    out_pkt  = '0;
    out_src  = '0;
    drop_cnt = '0;
    for (int j = 0; j < NPORT; j++) begin
      out_pkt[j*PKT_W +: PKT_W]    = opkt_q[j];
      out_src[j*DEST_W +: DEST_W]  = osrc_q[j];
      drop_cnt[j*CNT_W +: CNT_W]   = drops[j];
    end
  end

endmodule

// File: tb/tb_sw_rr.sv
// ---------------------------------------------------------------------------
// tb_sw_rr -- directed self-checking bench for sw_rr
//
// Two instances share one clock:
//   dut   : NPORT=4, DATA_W=8, DEPTH=4, CNT_W=8  (reset, latency, round-robin,
//           backpressure/full, mid-operation reset)
//   dut_b : NPORT=3, DATA_W=8, DEPTH=4, CNT_W=2  (invalid destination,
//           drop-counter saturation)
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_sw_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // Main instance, NPORT=4 -> DEST_W=2, PKT_W=10
  logic [3:0]  in_valid;
  logic [39:0] in_pkt;
  logic [3:0]  in_full;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [39:0] out_pkt;
  logic [7:0]  out_src;
  logic [31:0] drop_cnt;

  // Second instance, NPORT=3 -> DEST_W=2, PKT_W=10, CNT_W=2
  logic [2:0]  b_in_valid;
  logic [29:0] b_in_pkt;
  logic [2:0]  b_in_full;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready;
  logic [29:0] b_out_pkt;
  logic [5:0]  b_out_src;
  logic [5:0]  b_drop_cnt;

  sw_rr #(.NPORT(4), .DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pkt    (in_pkt),
    .in_full   (in_full),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt),
    .out_src   (out_src),
    .drop_cnt  (drop_cnt)
  );

  sw_rr #(.NPORT(3), .DATA_W(8), .DEPTH(4), .CNT_W(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_pkt    (b_in_pkt),
    .in_full   (b_in_full),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_pkt   (b_out_pkt),
    .out_src   (b_out_src),
    .drop_cnt  (b_drop_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] opkt(input int j);
    return out_pkt[j*10 +: 10];
  endfunction

  function automatic logic [1:0] osrc(input int j);
    return out_src[j*2 +: 2];
  endfunction

  task automatic send(input int i, input logic [1:0] dest, input logic [7:0] pay);
    in_valid[i]          = 1'b1;
    in_pkt[i*10 +: 10]   = {dest, pay};
  endtask

  task automatic b_send(input int i, input logic [1:0] dest, input logic [7:0] pay);
    b_in_valid[i]        = 1'b1;
    b_in_pkt[i*10 +: 10] = {dest, pay};
  endtask

  // Safety net: the stimulus is fixed-length, but never let the run hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    logic       exp_v;
    logic [7:0] exp_p;
    logic       exp_f;

    rst         = 1'b1;
    in_valid    = '0;
    in_pkt      = '0;
    out_ready   = 4'hF;
    b_in_valid  = '0;
    b_in_pkt    = '0;
    b_out_ready = 3'h7;

    // ---------------- Reset state ----------------
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_pkt",   out_pkt[31:0],  32'h0);
    check("rst_out_pkt_hi",32'(out_pkt[39:32]), 32'h0);
    check("rst_out_src",   32'(out_src),   32'h0);
    check("rst_drop_cnt",  drop_cnt,       32'h0);
    check("rst_in_full",   32'(in_full),   32'h0);
    check("rst_b_valid",   32'(b_out_valid), 32'h0);
    check("rst_b_drops",   32'(b_drop_cnt),  32'h0);

    // ---------------- Single packet, 2-cycle latency ----------------
    step();                              // cycle 0
    send(1, 2'd2, 8'hA5);
    step();                              // cycle 1
    in_valid = '0;
    check("single_c1_valid", 32'(out_valid), 32'h0);
    step();                              // cycle 2
    check("single_c2_valid", 32'(out_valid), 32'h4);
    check("single_c2_pkt",   32'(opkt(2)),   32'h2A5);
    check("single_c2_src",   32'(osrc(2)),   32'h1);
    step();                              // cycle 3
    check("single_c3_valid", 32'(out_valid), 32'h0);
    check("single_c3_hold",  32'(opkt(2)),   32'h2A5);

    // ---------------- Round-robin contention on output 0 ----------------
    // Input i's k-th packet carries payload 0x10*i + k.
    step();
    for (int c = 0; c < 15; c++) begin
      in_valid = '0;
      if (c < 3)
        for (int i = 0; i < 4; i++) send(i, 2'd0, 8'(16*i + c));
      if (c >= 2 && c < 14) begin
        t = c - 2;
        check("rr_valid", 32'(out_valid), 32'h1);
        check("rr_src",   32'(osrc(0)),   32'(t % 4));
        check("rr_pkt",   32'(opkt(0)),   32'({2'd0, 8'(16*(t % 4) + t / 4)}));
      end
      if (c == 14) begin
        check("rr_idle", 32'(out_valid), 32'h0);
        check("rr_drops", drop_cnt, 32'h0);
      end
      step();
    end

    // ---------------- Backpressure and full on input 0 -> output 3 ----------
    // Payloads 1..6 on cycles 0..5 with out_ready[3]=0; ready rises in cycle 7.
    for (int c = 0; c < 13; c++) begin
      in_valid     = '0;
      out_ready[3] = (c >= 7);
      if (c < 6) send(0, 2'd3, 8'(c + 1));
      exp_v = (c >= 2) && (c <= 11);
      exp_p = (c <= 7) ? 8'd1 : 8'(c - 6);
      exp_f = (c >= 5) && (c <= 7);
      check("bp_full",  32'(in_full[0]), 32'(exp_f));
      check("bp_valid", 32'(out_valid),  32'({exp_v, 3'b000}));
      if (exp_v) begin
        check("bp_pkt", 32'(opkt(3)), 32'({2'd3, exp_p}));
        check("bp_src", 32'(osrc(3)), 32'h0);
      end
      if (c == 6 || c == 12) check("bp_drop", drop_cnt, 32'h1);
      step();
    end
    out_ready = 4'hF;

    // ---------------- Reset mid-operation ----------------
    // Input 0 -> output 1 (6 packets, last one dropped), input 2 -> output 2
    // (5 packets, FIFO ends full). All outputs blocked.
    out_ready = 4'h0;
    for (int c = 0; c < 7; c++) begin
      in_valid = '0;
      if (c < 6) send(0, 2'd1, 8'(8'h30 + c));
      if (c < 5) send(2, 2'd2, 8'(8'h50 + c));
      if (c == 6) begin
        check("mid_pre_full",  32'(in_full),   32'h5);
        check("mid_pre_valid", 32'(out_valid), 32'h6);
        check("mid_pre_drop",  drop_cnt,       32'h2);
        rst = 1'b1;
      end
      step();
    end
    rst       = 1'b0;
    out_ready = 4'hF;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_full",  32'(in_full),   32'h0);
    check("mid_rst_drop",  drop_cnt,       32'h0);
    check("mid_rst_src",   32'(out_src),   32'h0);
    send(3, 2'd1, 8'h77);
    step();
    in_valid = '0;
    check("mid_c1_valid", 32'(out_valid), 32'h0);
    step();
    check("mid_c2_valid", 32'(out_valid), 32'h2);
    check("mid_c2_pkt",   32'(opkt(1)),   32'h177);
    check("mid_c2_src",   32'(osrc(1)),   32'h3);
    step();
    check("mid_c3_valid", 32'(out_valid), 32'h0);

    // ---------------- Invalid destination (NPORT=3) ----------------
    for (int c = 0; c < 6; c++) begin
      b_in_valid = '0;
      if (c == 0) b_send(0, 2'd3, 8'h11);
      if (c == 3) b_send(0, 2'd1, 8'h22);
      if (c >= 1) check("inv_drop", 32'(b_drop_cnt[1:0]), 32'h1);
      if (c <= 4) check("inv_quiet", 32'(b_out_valid), 32'h0);
      if (c == 5) begin
        check("inv_valid", 32'(b_out_valid),      32'h2);
        check("inv_pkt",   32'(b_out_pkt[19:10]), 32'h122);
        check("inv_src",   32'(b_out_src[3:2]),   32'h0);
      end
      step();
    end

    // ---------------- Drop-counter saturation (CNT_W=2) ----------------
    for (int c = 0; c < 7; c++) begin
      b_in_valid = '0;
      if (c < 5) b_send(2, 2'd3, 8'(c));
      if (c >= 1 && c <= 5)
        check("sat_drop", 32'(b_drop_cnt[5:4]), (c >= 3) ? 32'h3 : 32'(c));
      if (c == 6) begin
        check("sat_quiet",  32'(b_out_valid),      32'h0);
        check("sat_other",  32'(b_drop_cnt[1:0]),  32'h1);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
